// File: rtl/config_registers.sv
// config_registers: memory-mapped register bank with per-bit RW / W1C / RO classes.
// One request per cycle, registered response, per-word write strobe.

`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 3
`define MEM_COUNT_NONE 3'd0
`define MEM_COUNT_BYTE 3'd1
`define MEM_COUNT_HALF 3'd2
`define MEM_COUNT_WORD 3'd3
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 3
`define MEM_CODE_NONE 3'd0
`define MEM_CODE_READ 3'd1
`define MEM_CODE_WRITE 3'd2
`define MEM_CODE_MISALIGNED 3'd3
`define MEM_CODE_INVALID 3'd4
`endif

module config_registers #(
  parameter int WORD_COUNT = 4,
  parameter logic [`ADDR_W-1:0] ADDR_START = '0,
  parameter logic [WORD_COUNT*`WORD_W-1:0] RW_MASK = '1,
  parameter logic [WORD_COUNT*`WORD_W-1:0] W1C_MASK = '0,
  parameter logic [WORD_COUNT*`WORD_W-1:0] RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           aresetn,
  input  logic [`ADDR_W-1:0]             i_req_addr,
  input  logic [`MEM_COUNT_W-1:0]        i_req_count,
  input  logic                           i_req_wr,
  input  logic [`WORD_W-1:0]             i_req_wr_data,
  input  logic [WORD_COUNT*`WORD_W-1:0]  i_hw_value,
  input  logic [WORD_COUNT*`WORD_W-1:0]  i_hw_set,
  output logic [`WORD_W-1:0]             o_res_rd_data,
  output logic [`MEM_CODE_W-1:0]         o_res_code,
  output logic [WORD_COUNT*`WORD_W-1:0]  o_registers,
  output logic [WORD_COUNT-1:0]          o_wr_strobe
);

  localparam int TOTAL_W = WORD_COUNT * `WORD_W;
  // W1C takes precedence, so the RW class excludes W1C bits.
  localparam logic [TOTAL_W-1:0] RW_ONLY    = RW_MASK & ~W1C_MASK;
  localparam logic [TOTAL_W-1:0] STORE_MASK = RW_MASK | W1C_MASK;
  localparam logic [TOTAL_W-1:0] RO_MASK    = ~STORE_MASK;

  logic [`ADDR_W-1:0]     idx_full;
  logic                   in_range;
  logic                   misaligned;
  logic [4:0]             lane_shift;
  logic [`WORD_W-1:0]     size_mask;
  logic [`WORD_W-1:0]     lane_mask;
  logic [`WORD_W-1:0]     wdata_sh;
  logic [`WORD_W-1:0]     view;
  logic [`MEM_CODE_W-1:0] code_next;
  logic [`WORD_W-1:0]     rd_next;
  logic                   is_write;
  wire  [TOTAL_W-1:0]     stored_all;
  wire  [WORD_COUNT-1:0]  strobe_next;

  // Decode the request: range, alignment, lane selection and response code.
  always_comb begin
    idx_full   = (i_req_addr - ADDR_START) >> 2;
    in_range   = (i_req_addr >= ADDR_START) && (idx_full < `ADDR_W'(WORD_COUNT));
    misaligned = 1'b0;
    lane_shift = 5'd0;
    size_mask  = '1;
    code_next  = `MEM_CODE_NONE;
    case (i_req_count)
      `MEM_COUNT_NONE: code_next = `MEM_CODE_NONE;
      `MEM_COUNT_BYTE: begin
        lane_shift = {i_req_addr[1:0], 3'b000};
        size_mask  = `WORD_W'(8'hFF);
      end
      `MEM_COUNT_HALF: begin
        lane_shift = {i_req_addr[1], 4'b0000};
        size_mask  = `WORD_W'(16'hFFFF);
        misaligned = i_req_addr[0];
      end
      `MEM_COUNT_WORD: misaligned = (i_req_addr[1:0] != 2'b00);
      default: code_next = `MEM_CODE_INVALID;
    endcase
    if (i_req_count == `MEM_COUNT_BYTE || i_req_count == `MEM_COUNT_HALF ||
        i_req_count == `MEM_COUNT_WORD) begin
      if (misaligned)
        code_next = `MEM_CODE_MISALIGNED;
      else if (!in_range)
        code_next = `MEM_CODE_INVALID;
      else
        code_next = i_req_wr ? `MEM_CODE_WRITE : `MEM_CODE_READ;
    end
    lane_mask = size_mask << lane_shift;
    wdata_sh  = (i_req_wr_data & size_mask) << lane_shift;
    is_write  = (code_next == `MEM_CODE_WRITE);
  end

  // Build the read view of the addressed word and extract the requested lane.
  always_comb begin
    view = '0;
    for (int k = 0; k < WORD_COUNT; k++) begin
      if (idx_full == `ADDR_W'(k))
        view = (stored_all[k*`WORD_W +: `WORD_W] & STORE_MASK[k*`WORD_W +: `WORD_W]) |
               (i_hw_value[k*`WORD_W +: `WORD_W] & RO_MASK[k*`WORD_W +: `WORD_W]);
    end
    rd_next = (code_next == `MEM_CODE_READ) ? ((view >> lane_shift) & size_mask) : '0;
  end

  generate
    for (genvar gi = 0; gi < WORD_COUNT; gi++) begin : g_word
      localparam logic [`WORD_W-1:0] RW_K    = RW_ONLY[gi*`WORD_W +: `WORD_W];
      localparam logic [`WORD_W-1:0] W1C_K   = W1C_MASK[gi*`WORD_W +: `WORD_W];
      localparam logic [`WORD_W-1:0] RESET_K = RESET_VALUE[gi*`WORD_W +: `WORD_W] & RW_K;
      logic               hit;
      logic [`WORD_W-1:0] word_reg;
      logic [`WORD_W-1:0] word_next;

      assign hit = is_write && (idx_full == `ADDR_W'(gi));

      // Merge the write lane, clear W1C bits written with 1, then apply hardware sets (set wins).
      always_comb begin
        word_next = word_reg;
        if (hit) begin
          word_next = (word_next & ~(lane_mask & RW_K)) | (wdata_sh & lane_mask & RW_K);
          word_next = word_next & ~(wdata_sh & lane_mask & W1C_K);
        end
        word_next = word_next | (i_hw_set[gi*`WORD_W +: `WORD_W] & W1C_K);
        word_next = word_next & (RW_K | W1C_K);
      end

      // Storage register; RO positions stay constant zero.
      always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) word_reg <= RESET_K;
        else          word_reg <= word_next;
      end

      assign stored_all[gi*`WORD_W +: `WORD_W] = word_reg;
      assign strobe_next[gi] = hit;
    end
  endgenerate

  assign o_registers = stored_all;

  // Registered response path.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      o_res_rd_data <= '0;
      o_res_code    <= `MEM_CODE_NONE;
      o_wr_strobe   <= '0;
    end else begin
      o_res_rd_data <= rd_next;
      o_res_code    <= code_next;
      o_wr_strobe   <= strobe_next;
    end
  end

endmodule

// File: tb/tb_config_registers.sv
// tb_config_registers: table-driven check of config_registers plus W1C and reset sequences.

module tb_config_registers;

  localparam logic [2:0] C_NONE = 3'd0, C_BYTE = 3'd1, C_HALF = 3'd2, C_WORD = 3'd3;
  localparam logic [2:0] R_NONE = 3'd0, R_READ = 3'd1, R_WRITE = 3'd2, R_MIS = 3'd3, R_INV = 3'd4;

  logic         clk = 1'b0;
  logic         aresetn = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [2:0]   req_count = C_NONE;
  logic         req_wr = 1'b0;
  logic [31:0]  req_wr_data = '0;
  logic [127:0] hw_value = {32'hCAFE_F00D, 32'h2222_2222, 32'h1111_1111, 32'hFFFF_FFFF};
  logic [127:0] hw_set = '0;
  logic [31:0]  res_rd_data;
  logic [2:0]   res_code;
  logic [127:0] registers;
  logic [3:0]   wr_strobe;

  int total = 0;
  int bad = 0;

  config_registers #(
    .WORD_COUNT (4),
    .ADDR_START (32'h100),
    .RW_MASK    ({32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}),
    .W1C_MASK   ({32'h0, 32'h0000_00FF, 32'h0, 32'h0}),
    .RESET_VALUE({32'h0, 32'h0, 32'h0, 32'h0000_00A5})
  ) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .i_req_addr   (req_addr),
    .i_req_count  (req_count),
    .i_req_wr     (req_wr),
    .i_req_wr_data(req_wr_data),
    .i_hw_value   (hw_value),
    .i_hw_set     (hw_set),
    .o_res_rd_data(res_rd_data),
    .o_res_code   (res_code),
    .o_registers  (registers),
    .o_wr_strobe  (wr_strobe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  count;
    logic        wr;
    logic [31:0] wdata;
    logic [2:0]  exp_code;
    logic [31:0] exp_data;
    logic [3:0]  exp_strobe;
  } vec_t;

  vec_t vecs [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Present one request, let it be sampled, then sample the response 1 time unit after the edge.
  task automatic do_req(input logic [31:0] addr, input logic [2:0] count, input logic wr,
                        input logic [31:0] wdata);
    req_addr    = addr;
    req_count   = count;
    req_wr      = wr;
    req_wr_data = wdata;
    @(posedge clk);
    #1;
    req_count = C_NONE;
    req_wr    = 1'b0;
    $display("txn addr=0x%03h count=%0d wr=%0d wdata=0x%08h -> code=%0d data=0x%08h strobe=%b",
             addr, count, wr, wdata, res_code, res_rd_data, wr_strobe);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{32'h100, C_WORD, 1'b0, 32'h0,         R_READ,  32'h0000_00A5, 4'b0000};
    vecs[1]  = '{32'h104, C_WORD, 1'b1, 32'hDEAD_BEEF, R_WRITE, 32'h0,         4'b0010};
    vecs[2]  = '{32'h107, C_BYTE, 1'b0, 32'h0,         R_READ,  32'h0000_00DE, 4'b0000};
    vecs[3]  = '{32'h104, C_WORD, 1'b0, 32'h0,         R_READ,  32'hDEAD_BEEF, 4'b0000};
    vecs[4]  = '{32'h106, C_HALF, 1'b1, 32'h0000_1234, R_WRITE, 32'h0,         4'b0010};
    vecs[5]  = '{32'h104, C_WORD, 1'b0, 32'h0,         R_READ,  32'h1234_BEEF, 4'b0000};
    vecs[6]  = '{32'h105, C_HALF, 1'b1, 32'h0000_5555, R_MIS,   32'h0,         4'b0000};
    vecs[7]  = '{32'h104, C_WORD, 1'b0, 32'h0,         R_READ,  32'h1234_BEEF, 4'b0000};
    vecs[8]  = '{32'h104, C_HALF, 1'b0, 32'h0,         R_READ,  32'h0000_BEEF, 4'b0000};
    vecs[9]  = '{32'h105, C_BYTE, 1'b0, 32'h0,         R_READ,  32'h0000_00BE, 4'b0000};
    vecs[10] = '{32'h10C, C_WORD, 1'b0, 32'h0,         R_READ,  32'hCAFE_F00D, 4'b0000};
    vecs[11] = '{32'h10C, C_WORD, 1'b1, 32'hFFFF_FFFF, R_WRITE, 32'h0,         4'b1000};
    vecs[12] = '{32'h10C, C_WORD, 1'b0, 32'h0,         R_READ,  32'hCAFE_F00D, 4'b0000};
    vecs[13] = '{32'h110, C_WORD, 1'b0, 32'h0,         R_INV,   32'h0,         4'b0000};
    vecs[14] = '{32'h0FC, C_WORD, 1'b0, 32'h0,         R_INV,   32'h0,         4'b0000};
    vecs[15] = '{32'h0FC, C_WORD, 1'b1, 32'h1234_5678, R_INV,   32'h0,         4'b0000};
    vecs[16] = '{32'h100, C_NONE, 1'b1, 32'hFFFF_FFFF, R_NONE,  32'h0,         4'b0000};
    vecs[17] = '{32'h100, 3'd5,   1'b0, 32'h0,         R_INV,   32'h0,         4'b0000};
    vecs[18] = '{32'h101, C_BYTE, 1'b1, 32'h0000_0077, R_WRITE, 32'h0,         4'b0001};
    vecs[19] = '{32'h100, C_WORD, 1'b0, 32'h0,         R_READ,  32'h0000_77A5, 4'b0000};
    vecs[20] = '{32'h111, C_HALF, 1'b0, 32'h0,         R_MIS,   32'h0,         4'b0000};
    vecs[21] = '{32'h108, C_WORD, 1'b0, 32'h0,         R_READ,  32'h0,         4'b0000};

    // Reset state.
    #12;
    check("reset_code",   32'(res_code), 32'(R_NONE));
    check("reset_data",   res_rd_data, 32'h0);
    check("reset_strobe", 32'(wr_strobe), 32'h0);
    check("reset_reg0",   registers[31:0], 32'h0000_00A5);
    check("reset_reg3",   registers[127:96], 32'h0);
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);

    // Table-driven vectors.
    for (int i = 0; i < 22; i++) begin
      do_req(vecs[i].addr, vecs[i].count, vecs[i].wr, vecs[i].wdata);
      check($sformatf("vec%0d_code", i),   32'(res_code),  32'(vecs[i].exp_code));
      check($sformatf("vec%0d_data", i),   res_rd_data,    vecs[i].exp_data);
      check($sformatf("vec%0d_strobe", i), 32'(wr_strobe), 32'(vecs[i].exp_strobe));
    end
    check("reg1_after_writes", registers[63:32], 32'h1234_BEEF);
    check("reg3_ro_storage",   registers[127:96], 32'h0);
    idle_cycle();
    check("strobe_one_cycle", 32'(wr_strobe), 32'h0);

    // W1C: hardware set then read.
    hw_set[64+3] = 1'b1;
    idle_cycle();
    hw_set = '0;
    check("w1c_set_reg", registers[95:64], 32'h0000_0008);
    do_req(32'h108, C_WORD, 1'b0, 32'h0);
    check("w1c_set_read", res_rd_data, 32'h0000_0008);

    // W1C: clear by writing 1.
    do_req(32'h108, C_WORD, 1'b1, 32'h0000_0008);
    check("w1c_clear_code",   32'(res_code), 32'(R_WRITE));
    check("w1c_clear_strobe", 32'(wr_strobe), 32'h4);
    do_req(32'h108, C_WORD, 1'b0, 32'h0);
    check("w1c_clear_read", res_rd_data, 32'h0);

    // W1C: set and clear in the same cycle, set wins.
    hw_set[64+3] = 1'b1;
    do_req(32'h108, C_BYTE, 1'b1, 32'h0000_0008);
    hw_set = '0;
    do_req(32'h108, C_WORD, 1'b0, 32'h0);
    check("w1c_set_wins", res_rd_data, 32'h0000_0008);

    // Reset mid-stream: a pending read response is dropped at once.
    do_req(32'h104, C_WORD, 1'b0, 32'h0);
    check("pre_reset_data", res_rd_data, 32'h1234_BEEF);
    #2;
    aresetn = 1'b0;
    #1;
    check("midreset_code", 32'(res_code), 32'(R_NONE));
    check("midreset_data", res_rd_data, 32'h0);
    check("midreset_reg1", registers[63:32], 32'h0);
    check("midreset_reg0", registers[31:0], 32'h0000_00A5);
    check("midreset_reg2", registers[95:64], 32'h0);
    do_req(32'h104, C_WORD, 1'b1, 32'h5555_5555);
    check("inreset_strobe", 32'(wr_strobe), 32'h0);
    @(negedge clk);
    aresetn = 1'b1;
    do_req(32'h100, C_WORD, 1'b0, 32'h0);
    check("post_reset_read", res_rd_data, 32'h0000_00A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
